soc_dmem_ctrl: RTL and testbench
================================

Name: soc_dmem_ctrl

Overview:
Parametrised data-memory controller between the core's dmem port and the SoC data resources. It decodes each access to one of two regions: the on-chip RAM, or a block of memory-mapped I/O registers. The I/O registers are a GPIO output register (drives the board LEDs) and a 16-bit timer with compare and interrupt. It gives every read a uniform 1-cycle latency with a read-valid strobe.

Parameters:
DMEM_WIDTH, 9, core data address width; must be greater than RAM_WIDTH.
RAM_WIDTH, 8, RAM address width; addresses below 2^RAM_WIDTH select the RAM, all others select I/O.
GPIO_WIDTH, 8, GPIO output width, 1..8.
TIMER_WIDTH, 16, timer counter width, 1..16; unused upper register bits read 0.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dmem_re  in  1  core read request, single-cycle
dmem_we  in  1  core write request, single-cycle
dmem_a  in  DMEM_WIDTH  core byte address
dmem_di  in  8  core write data
dmem_do  out  8  read data to core
dmem_rvalid  out  1  read data valid, 1 cycle after accepted read
ram_re  out  1  RAM read enable
ram_we  out  1  RAM write enable
ram_a  out  RAM_WIDTH  RAM address
ram_di  out  8  RAM write data
ram_do  in  8  RAM read data; synchronous, valid 1 cycle after ram_re, held until next read
gpio_out  out  GPIO_WIDTH  LED/GPIO outputs
timer_irq  out  1  timer interrupt, level

Behaviour:
Decode:
- is_ram = (dmem_a < 2^RAM_WIDTH).
- I/O offset = dmem_a[2:0]. Bits above bit 2 within the I/O region are ignored, so the 8-byte map aliases.

RAM path (combinational):
- ram_a = dmem_a[RAM_WIDTH-1:0], ram_di = dmem_di.
- ram_we = dmem_we & is_ram.
- ram_re = dmem_re & ~dmem_we & is_ram.

I/O map, by offset:
- 0 GPIO: R/W, reset 0.
- 1 GPIO_TGL: write XORs dmem_di into GPIO; read returns GPIO.
- 2 CNT_L: read returns count[7:0] and latches count[15:8] into a shadow register in the same cycle; any write clears count to 0.
- 3 CNT_H: read returns the shadow; writes ignored.
- 4 CMP_L: R/W, reset 0xFF.
- 5 CMP_H: R/W, reset 0xFF.
- 6 CTRL: bit0 EN (R/W, reset 0); bit1 FLAG (read; writing 1 clears it); bit2 IE (R/W, reset 0); bits 7:3 read 0.
- 7: reserved, reads 0, writes ignored.

Timer:
- When EN=1, each cycle: if count == compare, then count <= 0 and FLAG <= 1; else count <= count+1.
- Count wraps naturally at 2^TIMER_WIDTH if compare lies above that range.
- When EN=0, count holds.
- A CNT_L write in the same cycle as an increment or match: the write wins and count becomes 0. FLAG still sets if a match occurred that cycle.
- FLAG set and a write-1-clear in the same cycle: set wins.
- compare=0 with EN=1: count stays 0 and FLAG re-sets every cycle.
- timer_irq = FLAG & IE.

Reads:
- A read is accepted when dmem_re=1 and dmem_we=0.
- dmem_rvalid is registered: 1 exactly in the cycle after an accepted read, otherwise 0.
- The I/O read value is sampled at the request edge, before that edge's updates, and stored in io_q. A region select sel_q is registered with it.
- dmem_do = sel_q ? ram_do : io_q.
- dmem_do holds its value until the next accepted read.
- dmem_re and dmem_we asserted together: treated as a write only; no read, no rvalid.
- Back-to-back reads every cycle: rvalid is continuously 1 and data is pipelined.

Reset (async, asserted while rst_n=0):
- dmem_rvalid=0, dmem_do=0 (sel_q selects I/O, io_q=0), gpio_out=0, timer_irq=0.
- count=0, shadow=0, compare=all ones, EN=0, IE=0, FLAG=0.
- A read pending when reset asserts is dropped; no rvalid follows.

Test Plan:
- Write 0xA5 to addr 0x010, then read 0x010 -> ram_we pulse with ram_a=0x10; 1 cycle after the read, rvalid=1 and dmem_do=0xA5.
- Write 0x3C to GPIO (0x100), then 0xFF to GPIO_TGL (0x101) -> gpio_out 0x3C then 0xC3; read 0x100 returns 0xC3 with rvalid 1 cycle later.
- CMP=0x0004, IE=1, EN=1 via CTRL=0x05 -> count runs 0,1,2,3,4,0; FLAG and timer_irq rise on the wrap; writing CTRL=0x07 clears them; the next match re-asserts them.
- EN=1, CMP=0xFFFF, run 300 cycles, read CNT_L then CNT_H -> 16-bit value consistent with the moment of the CNT_L read; the CNT_H value does not change with later cycles.
- Assert re and we together at 0x020 -> write occurs, ram_re=0, no rvalid; reads to offset 7 and CTRL[7:3] return 0.
- Drop rst_n mid-read and mid-count -> all outputs 0 immediately, no rvalid after release, compare reads 0xFF/0xFF.

Source files
------------

// File: rtl/soc_dmem_ctrl.sv
// soc_dmem_ctrl
// Data-memory controller between the core dmem port and the SoC data
// resources. Each access is decoded to either the on-chip RAM (addresses
// below 2^RAM_WIDTH) or an 8-byte I/O block that aliases across the rest of
// the address space. The I/O block holds a GPIO output register and a timer
// with compare match, sticky flag and interrupt enable. Every accepted read
// returns data exactly one cycle later together with dmem_rvalid.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   dmem_re, dmem_we    core read / write strobes (write wins if both set)
//   dmem_a, dmem_di     core byte address and write data
//   dmem_do             read data, held until the next accepted read
//   dmem_rvalid         one-cycle strobe following an accepted read
//   ram_re, ram_we      RAM strobes, gated by the RAM region decode
//   ram_a, ram_di       RAM address and write data (direct from the core)
//   ram_do              synchronous RAM read data, valid one cycle after ram_re
//   gpio_out            GPIO / LED outputs
//   timer_irq           timer interrupt level (FLAG & IE)
module soc_dmem_ctrl #(
  parameter int DMEM_WIDTH  = 9,
  parameter int RAM_WIDTH   = 8,
  parameter int GPIO_WIDTH  = 8,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dmem_re,
  input  logic                   dmem_we,
  input  logic [DMEM_WIDTH-1:0]  dmem_a,
  input  logic [7:0]             dmem_di,
  output logic [7:0]             dmem_do,
  output logic                   dmem_rvalid,
  output logic                   ram_re,
  output logic                   ram_we,
  output logic [RAM_WIDTH-1:0]   ram_a,
  output logic [7:0]             ram_di,
  input  logic [7:0]             ram_do,
  output logic [GPIO_WIDTH-1:0]  gpio_out,
  output logic                   timer_irq
);

  localparam logic [2:0] OFF_GPIO     = 3'd0;
  localparam logic [2:0] OFF_GPIO_TGL = 3'd1;
  localparam logic [2:0] OFF_CNT_L    = 3'd2;
  localparam logic [2:0] OFF_CNT_H    = 3'd3;
  localparam logic [2:0] OFF_CMP_L    = 3'd4;
  localparam logic [2:0] OFF_CMP_H    = 3'd5;
  localparam logic [2:0] OFF_CTRL     = 3'd6;

  // Decode
  logic       is_ram;
  logic       rd_acc;
  logic       io_wr;
  logic       io_rd;
  logic [2:0] io_off;

  assign is_ram = ~|dmem_a[DMEM_WIDTH-1:RAM_WIDTH];
  assign rd_acc = dmem_re & ~dmem_we;
  assign io_wr  = dmem_we & ~is_ram;
  assign io_rd  = rd_acc & ~is_ram;
  assign io_off = dmem_a[2:0];

  // RAM path is purely combinational
  assign ram_a  = dmem_a[RAM_WIDTH-1:0];
  assign ram_di = dmem_di;
  assign ram_we = dmem_we & is_ram;
  assign ram_re = rd_acc & is_ram;

  // State
  logic [GPIO_WIDTH-1:0]  gpio_reg, gpio_next;
  logic [TIMER_WIDTH-1:0] count_reg, count_next;
  logic [TIMER_WIDTH-1:0] cmp_reg, cmp_next;
  logic [7:0]             shadow_reg, shadow_next;
  logic                   en_reg, en_next;
  logic                   ie_reg, ie_next;
  logic                   flag_reg, flag_next;
  logic [7:0]             io_q_reg, io_q_next;
  logic                   sel_q_reg, sel_q_next;
  logic                   rvalid_reg, rvalid_next;

  // Zero-extended views so narrow timer/GPIO configurations read back with
  // their unused upper register bits as 0.
  logic [15:0] count16;
  logic [15:0] cmp16;
  logic [7:0]  gpio8;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_timer_ext
      if (gi < TIMER_WIDTH) begin : g_used
        assign count16[gi] = count_reg[gi];
        assign cmp16[gi]   = cmp_reg[gi];
      end else begin : g_pad
        assign count16[gi] = 1'b0;
        assign cmp16[gi]   = 1'b0;
      end
    end
    for (gi = 0; gi < 8; gi++) begin : g_gpio_ext
      if (gi < GPIO_WIDTH) begin : g_used
        assign gpio8[gi] = gpio_reg[gi];
      end else begin : g_pad
        assign gpio8[gi] = 1'b0;
      end
    end
  endgenerate

  // I/O read mux, evaluated on pre-edge state
  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      OFF_GPIO, OFF_GPIO_TGL: io_rdata = gpio8;
      OFF_CNT_L:              io_rdata = count16[7:0];
      OFF_CNT_H:              io_rdata = shadow_reg;
      OFF_CMP_L:              io_rdata = cmp16[7:0];
      OFF_CMP_H:              io_rdata = cmp16[15:8];
      OFF_CTRL:               io_rdata = {5'b00000, ie_reg, flag_reg, en_reg};
      default:                io_rdata = 8'h00;
    endcase
  end

  // Timer compare and byte-wise compare-register update
  logic        match;
  logic [15:0] cmp16_wr;

  assign match = (count_reg == cmp_reg);

  always_comb begin
    cmp16_wr = cmp16;
    if (io_wr && io_off == OFF_CMP_L) cmp16_wr[7:0]  = dmem_di;
    if (io_wr && io_off == OFF_CMP_H) cmp16_wr[15:8] = dmem_di;
  end

  // Next-state logic
  always_comb begin
    gpio_next   = gpio_reg;
    count_next  = count_reg;
    cmp_next    = cmp16_wr[TIMER_WIDTH-1:0];
    shadow_next = shadow_reg;
    en_next     = en_reg;
    ie_next     = ie_reg;
    flag_next   = flag_reg;
    io_q_next   = io_q_reg;
    sel_q_next  = sel_q_reg;
    rvalid_next = rd_acc;

    if (io_wr && io_off == OFF_GPIO)     gpio_next = dmem_di[GPIO_WIDTH-1:0];
    if (io_wr && io_off == OFF_GPIO_TGL) gpio_next = gpio_reg ^ dmem_di[GPIO_WIDTH-1:0];

    if (io_wr && io_off == OFF_CTRL) begin
      en_next = dmem_di[0];
      ie_next = dmem_di[2];
      if (dmem_di[1]) flag_next = 1'b0;
    end

    // Count runs freely up to compare; a CNT_L write overrides whatever the
    // timer would have done this cycle, but a match still raises FLAG.
    if (en_reg) begin
      if (match) begin
        count_next = '0;
        flag_next  = 1'b1;
      end else begin
        count_next = count_reg + TIMER_WIDTH'(1);
      end
    end
    if (io_wr && io_off == OFF_CNT_L) count_next = '0;

    // Reading CNT_L snapshots the upper byte so a following CNT_H read is
    // coherent with the low byte.
    if (io_rd && io_off == OFF_CNT_L) shadow_next = count16[15:8];

    if (rd_acc) begin
      sel_q_next = is_ram;
      if (!is_ram) io_q_next = io_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_reg   <= '0;
      count_reg  <= '0;
      cmp_reg    <= '1;
      shadow_reg <= 8'h00;
      en_reg     <= 1'b0;
      ie_reg     <= 1'b0;
      flag_reg   <= 1'b0;
      io_q_reg   <= 8'h00;
      sel_q_reg  <= 1'b0;
      rvalid_reg <= 1'b0;
    end else begin
      gpio_reg   <= gpio_next;
      count_reg  <= count_next;
      cmp_reg    <= cmp_next;
      shadow_reg <= shadow_next;
      en_reg     <= en_next;
      ie_reg     <= ie_next;
      flag_reg   <= flag_next;
      io_q_reg   <= io_q_next;
      sel_q_reg  <= sel_q_next;
      rvalid_reg <= rvalid_next;
    end
  end

  assign dmem_do     = sel_q_reg ? ram_do : io_q_reg;
  assign dmem_rvalid = rvalid_reg;
  assign gpio_out    = gpio_reg;
  assign timer_irq   = flag_reg & ie_reg;

endmodule

// File: tb/tb_soc_dmem_ctrl.sv
// Testbench for soc_dmem_ctrl: expected read data is queued when each read is
// driven and popped when the read-valid strobe is sampled.
module tb_soc_dmem_ctrl;

  logic       clk;
  logic       rst_n;
  logic       dmem_re;
  logic       dmem_we;
  logic [8:0] dmem_a;
  logic [7:0] dmem_di;
  logic [7:0] dmem_do;
  logic       dmem_rvalid;
  logic       ram_re;
  logic       ram_we;
  logic [7:0] ram_a;
  logic [7:0] ram_di;
  logic [7:0] ram_do;
  logic [7:0] gpio_out;
  logic       timer_irq;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  soc_dmem_ctrl #(
    .DMEM_WIDTH (9),
    .RAM_WIDTH  (8),
    .GPIO_WIDTH (8),
    .TIMER_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_a     (dmem_a),
    .dmem_di    (dmem_di),
    .dmem_do    (dmem_do),
    .dmem_rvalid(dmem_rvalid),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_a      (ram_a),
    .ram_di     (ram_di),
    .ram_do     (ram_do),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: data valid one cycle after ram_re, held otherwise.
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    if (ram_re) ram_do <= mem[ram_a];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    dmem_re = 1'b0;
    dmem_we = 1'b0;
  endtask

  task automatic drv_rd(input logic [8:0] a, input logic [7:0] e);
    dmem_re = 1'b1;
    dmem_we = 1'b0;
    dmem_a  = a;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    dmem_re = 1'b0;
    dmem_we = 1'b1;
    dmem_a  = a;
    dmem_di = d;
    tick();
    drv_idle();
  endtask

  task automatic test_reset();
    logic [8:0] addrs [5];
    logic [7:0] exps [5];
    logic [7:0] e;
    addrs = '{9'h104, 9'h105, 9'h106, 9'h102, 9'h100};
    exps  = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0;
    drv_idle();
    dmem_a = '0;
    dmem_di = '0;
    #3;
    vectors++;
    if (dmem_rvalid !== 1'b0 || dmem_do !== 8'h00 || gpio_out !== 8'h00 || timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: rvalid=%b do=%02h gpio=%02h irq=%b, want 0/00/00/0",
               dmem_rvalid, dmem_do, gpio_out, timer_irq);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv_rd(addrs[i], exps[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
        miscompares++;
        $display("FAIL reset_reg[%03h]: rvalid=%b do=%02h, want rvalid=1 do=%02h",
                 addrs[i], dmem_rvalid, dmem_do, e);
      end
    end
    drv_idle();
    tick();
  endtask

  task automatic test_ram();
    logic [7:0] e;
    dmem_we = 1'b1; dmem_re = 1'b0; dmem_a = 9'h010; dmem_di = 8'hA5;
    #1;
    vectors++;
    if (ram_we !== 1'b1 || ram_a !== 8'h10 || ram_di !== 8'hA5 || ram_re !== 1'b0) begin
      miscompares++;
      $display("FAIL ram_write_strobe: we=%b re=%b a=%02h di=%02h, want we=1 re=0 a=10 di=a5",
               ram_we, ram_re, ram_a, ram_di);
    end
    tick();
    drv_rd(9'h010, 8'hA5);
    #1;
    vectors++;
    if (ram_re !== 1'b1 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL ram_read_strobe: re=%b we=%b, want re=1 we=0", ram_re, ram_we);
    end
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL ram_read: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    tick();
    vectors++;
    if (dmem_rvalid !== 1'b0 || dmem_do !== 8'hA5) begin
      miscompares++;
      $display("FAIL ram_hold: rvalid=%b do=%02h, want rvalid=0 do=a5", dmem_rvalid, dmem_do);
    end
  endtask

  task automatic test_gpio();
    logic [7:0] e;
    wr(9'h100, 8'h3C);
    vectors++;
    if (gpio_out !== 8'h3C) begin
      miscompares++;
      $display("FAIL gpio_write: gpio=%02h, want 3c", gpio_out);
    end
    wr(9'h101, 8'hFF);
    vectors++;
    if (gpio_out !== 8'hC3) begin
      miscompares++;
      $display("FAIL gpio_toggle: gpio=%02h, want c3", gpio_out);
    end
    drv_rd(9'h100, 8'hC3);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL gpio_read: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    // Aliased toggle address in the upper part of the I/O region
    wr(9'h1F9, 8'h0F);
    vectors++;
    if (gpio_out !== 8'hCC) begin
      miscompares++;
      $display("FAIL gpio_alias_toggle: gpio=%02h, want cc", gpio_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] addrs [6];
    logic [7:0] exps [6];
    logic [7:0] e;
    wr(9'h030, 8'h11);
    wr(9'h031, 8'h22);
    wr(9'h032, 8'h33);
    wr(9'h033, 8'h44);
    addrs = '{9'h030, 9'h100, 9'h031, 9'h032, 9'h107, 9'h033};
    exps  = '{8'h11, 8'hCC, 8'h22, 8'h33, 8'h00, 8'h44};
    for (int i = 0; i < 6; i++) begin
      drv_rd(addrs[i], exps[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d] addr=%03h: rvalid=%b do=%02h, want rvalid=1 do=%02h",
                 i, addrs[i], dmem_rvalid, dmem_do, e);
      end
    end
    drv_idle();
    tick();
  endtask

  task automatic test_timer();
    logic [7:0] cnt_exp [6];
    logic [7:0] e;
    cnt_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0};
    wr(9'h104, 8'h04);
    wr(9'h105, 8'h00);
    wr(9'h106, 8'h05);
    for (int k = 0; k < 6; k++) begin
      drv_rd(9'h102, cnt_exp[k]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e || timer_irq !== (k >= 4)) begin
        miscompares++;
        $display("FAIL timer_run[%0d]: rvalid=%b cnt=%02h irq=%b, want rvalid=1 cnt=%02h irq=%b",
                 k, dmem_rvalid, dmem_do, timer_irq, e, (k >= 4));
      end
    end
    drv_idle();
    wr(9'h106, 8'h07);
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL timer_clear: irq=%b, want 0", timer_irq);
    end
    tick();
    tick();
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL timer_premature: irq=%b, want 0", timer_irq);
    end
    tick();
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL timer_rematch: irq=%b, want 1", timer_irq);
    end
    drv_rd(9'h106, 8'h07);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL timer_ctrl_read: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    // Disable: the edge that writes EN=0 still advances count from 1 to 2
    wr(9'h106, 8'h02);
    tick();
    tick();
    drv_rd(9'h102, 8'h02);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e || timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL timer_hold: rvalid=%b cnt=%02h irq=%b, want rvalid=1 cnt=%02h irq=0",
               dmem_rvalid, dmem_do, timer_irq, e);
    end
    drv_idle();
  endtask

  task automatic test_counter_snapshot();
    logic [7:0] e;
    wr(9'h104, 8'hFF);
    wr(9'h105, 8'hFF);
    wr(9'h106, 8'h01);
    wr(9'h102, 8'h00);
    repeat (300) tick();
    drv_rd(9'h102, 8'h2C);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL cnt_l_300: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_rd(9'h103, 8'h01);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL cnt_h_300: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    repeat (20) tick();
    drv_rd(9'h103, 8'h01);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL cnt_h_stable: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    wr(9'h106, 8'h00);
  endtask

  task automatic test_reserved();
    logic [8:0] addrs [3];
    logic [7:0] exps [3];
    logic [7:0] e;
    dmem_re = 1'b1; dmem_we = 1'b1; dmem_a = 9'h020; dmem_di = 8'h77;
    #1;
    vectors++;
    if (ram_re !== 1'b0 || ram_we !== 1'b1) begin
      miscompares++;
      $display("FAIL re_we_strobes: ram_re=%b ram_we=%b, want 0/1", ram_re, ram_we);
    end
    tick();
    drv_idle();
    vectors++;
    if (dmem_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL re_we_no_rvalid: rvalid=%b, want 0", dmem_rvalid);
    end
    wr(9'h107, 8'hFF);
    wr(9'h106, 8'hF8);
    addrs = '{9'h020, 9'h107, 9'h106};
    exps  = '{8'h77, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      drv_rd(addrs[i], exps[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
        miscompares++;
        $display("FAIL reserved[%03h]: rvalid=%b do=%02h, want rvalid=1 do=%02h",
                 addrs[i], dmem_rvalid, dmem_do, e);
      end
    end
    drv_idle();
    wr(9'h106, 8'hFC);
    drv_rd(9'h106, 8'h04);
    tick();
    e = exp_q.pop_front();
    vectors++;
    if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
      miscompares++;
      $display("FAIL ctrl_ie_only: rvalid=%b do=%02h, want rvalid=1 do=%02h", dmem_rvalid, dmem_do, e);
    end
    drv_idle();
    wr(9'h106, 8'h00);
  endtask

  task automatic test_async_reset();
    logic [8:0] addrs [4];
    logic [7:0] exps [4];
    logic [7:0] e;
    // compare=0: count pinned at 0 and FLAG re-set every cycle
    wr(9'h104, 8'h00);
    wr(9'h105, 8'h00);
    wr(9'h106, 8'h05);
    wr(9'h102, 8'h00);
    tick();
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL cmp0_flag: irq=%b, want 1", timer_irq);
    end
    wr(9'h106, 8'h07);
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL set_beats_clear: irq=%b, want 1", timer_irq);
    end
    addrs = '{9'h102, 9'h106, 9'h100, 9'h100};
    exps  = '{8'h00, 8'h07, 8'hCC, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      drv_rd(addrs[i], exps[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
        miscompares++;
        $display("FAIL pre_reset[%03h]: rvalid=%b do=%02h, want rvalid=1 do=%02h",
                 addrs[i], dmem_rvalid, dmem_do, e);
      end
    end
    // Read still requested; reset lands mid-cycle
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (dmem_rvalid !== 1'b0 || dmem_do !== 8'h00 || gpio_out !== 8'h00 || timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: rvalid=%b do=%02h gpio=%02h irq=%b, want 0/00/00/0",
               dmem_rvalid, dmem_do, gpio_out, timer_irq);
    end
    tick();
    tick();
    rst_n = 1'b1;
    drv_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dmem_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_rvalid[%0d]: rvalid=%b, want 0", i, dmem_rvalid);
      end
    end
    addrs = '{9'h104, 9'h105, 9'h106, 9'h102};
    exps  = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      drv_rd(addrs[i], exps[i]);
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (dmem_rvalid !== 1'b1 || dmem_do !== e) begin
        miscompares++;
        $display("FAIL post_reset[%03h]: rvalid=%b do=%02h, want rvalid=1 do=%02h",
                 addrs[i], dmem_rvalid, dmem_do, e);
      end
    end
    drv_idle();
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_ram();
    test_gpio();
    test_back_to_back();
    test_timer();
    test_counter_snapshot();
    test_reserved();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
